load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the execute stage and Data_Memory. Accepts one load/store request at a time, carrying a byte address (the ALU result).
- Drives Data_Memory's word-indexed port and performs sign or zero extension for LB/LH/LBU/LHU.
- Implements SB/SH as read-modify-write, because Data_Memory only writes full words.
- Returns one response pulse per request, with an error flag for misaligned, illegal-size or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 2048, number of 32-bit words in Data_Memory; word index >= DEPTH_WORDS is out of range.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_write  input  1  1=store, 0=load
- req_size  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only (stores)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/half used for SB/SH
- dmem_addr  output  32  word index = latched addr[31:2], zero-extended
- dmem_read  output  1  to Data_Memory mem_read
- dmem_write  output  1  to Data_Memory mem_write
- dmem_wdata  output  32  to Data_Memory read_b
- dmem_rdata  input  32  from Data_Memory read_data; valid the cycle after a posedge with dmem_read=1
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE; resp_valid, resp_rdata, resp_err, dmem_read, dmem_write, dmem_wdata and latched registers all 0.
  - An in-flight operation is abandoned; no dmem_write may be asserted after reset rises.
- Accept: at a rising edge with req_valid && req_ready. Latch write, size, addr and wdata. Inputs are ignored outside IDLE.
- dmem_* outputs are decoded from state and latched registers only, never from req_* inputs.
- Error check at accept:
  - H/HU/SH with addr[0]=1 is an error.
  - W/SW with addr[1:0]!=0 is an error.
  - Size codes 011/11x, or 100/101 with req_write=1, are errors.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - On error: go to RESP. No dmem access. resp_err=1, resp_rdata=0.
- States:
  - IDLE:
    - Valid error-free load or sub-word store -> RD.
    - Error-free SW -> WR (dmem_wdata = wdata).
    - Error -> RESP.
  - RD: dmem_read=1 -> next WAIT.
  - WAIT: dmem_rdata is valid.
    - Load: register resp_rdata = extended selected lane -> RESP.
    - SB/SH: register merged word (lane addr[1:0] for byte, addr[1] for half, replaced by wdata low bits) into dmem_wdata -> WR.
  - WR: dmem_write=1 for exactly one cycle -> RESP.
  - RESP: resp_valid=1 for one cycle (rdata/err as set) -> IDLE. resp_valid is registered and deasserted in every other state.
- Lane selection is little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Latency, with accept edge = E0 and resp_valid high in the cycle after edge:
  - Load: E3.
  - SW: E2.
  - SB/SH: E4.
  - Error: E1.
- Back-to-back: req_ready rises in the cycle after the resp_valid cycle. There is no response back-pressure; the consumer always accepts.
- Exactly one dmem_read and zero dmem_write per load. Exactly one dmem_write per store, plus one dmem_read for SB/SH.

Test Plan:
- Preload word 5 = 0x876543A1. LB 0x14 -> resp_rdata 0xFFFFFFA1. LBU 0x14 -> 0x000000A1. LB 0x17 -> 0xFFFFFF87. Each with resp_valid in cycle after E3, err=0.
- LH 0x16 -> 0xFFFF8765. LHU 0x16 -> 0x00008765. LW 0x14 -> 0x876543A1.
- SB 0x15, wdata 0x123456CC:
  - Exactly one dmem_read, then one dmem_write of 0x8765CCA1 to index 5.
  - Subsequent LW 0x14 -> 0x8765CCA1.
- Error cases, each giving resp_err=1, resp_rdata=0, resp_valid in cycle after E1, and zero dmem_read/dmem_write:
  - LW 0x16.
  - SH 0x15.
  - LB 0x2000 (index 2048).
  - Store with size 100.
- Reset asserted asynchronously while in WAIT of SB 0x14:
  - Outputs go to 0 immediately, with no dmem_write.
  - Word 5 is unchanged; req_ready=1 in the first cycle after reset release.
- Back-to-back SW 0x20 then LW 0x20 with req_valid held high:
  - Second accept occurs in the cycle after the first resp_valid.
  - LW returns the stored value.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed Data_Memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module load_store_unit #(
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_valid_q, resp_valid_d;

  logic        accept;
  logic        size_bad, misaligned, out_of_range, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Ready stays low during the response cycle so the next accept follows it.
  assign req_ready  = (state_q == S_IDLE) && !resp_valid_q;
  assign accept     = req_valid && req_ready;
  assign dmem_addr  = {2'b00, addr_q[31:2]};
  assign dmem_read  = (state_q == S_RD);
  assign dmem_write = (state_q == S_WR);
  assign dmem_wdata = dmem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    case (req_size)
      3'b000, 3'b001, 3'b010: size_bad = 1'b0;
      3'b100, 3'b101:         size_bad = req_write;
      default:                size_bad = 1'b1;
    endcase
    misaligned   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_size == 3'b010) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
    req_err      = size_bad || misaligned || out_of_range;
  end

  always_comb begin
    byte_sel = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
    merged = dmem_rdata;
    if (size_q[0] == 1'b0) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d      = req_write;
          size_d       = req_size;
          addr_d       = req_addr;
          wdata_d      = req_wdata[15:0];
          resp_rdata_d = '0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (req_write && (req_size == 3'b010)) begin
            dmem_wdata_d = req_wdata;
            state_d      = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        if (write_q) begin
          dmem_wdata_d = merged;
          state_d      = S_WR;
        end else begin
          resp_rdata_d = load_ext;
          state_d      = S_RESP;
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dmem_wdata_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule
